// File: rtl/ftdi_cmd_parser_if.sv
// Bridge and register-bus signal bundle for ftdi_cmd_parser.
// Latency: none; wires only.
// Backpressure: rd_gnt stalls RX consumption; wr_gnt holds each TX byte.
interface ftdi_cmd_parser_if;
    logic       rd_req;
    logic       rd_gnt;
    logic [7:0] rd_data;
    logic       wr_req;
    logic       wr_gnt;
    logic [7:0] wr_data;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic [7:0] reg_rdata;

    // master = command parser, slave = bridge FIFOs plus register file
    modport master (
        output rd_req, input rd_gnt, input rd_data,
        output wr_req, input wr_gnt, output wr_data,
        output reg_we, output reg_re, output reg_addr, output reg_wdata,
        input  reg_rdata
    );
    modport slave (
        input  rd_req, output rd_gnt, output rd_data,
        input  wr_req, output wr_gnt, input wr_data,
        input  reg_we, input reg_re, input reg_addr, input reg_wdata,
        output reg_rdata
    );
endinterface

// File: rtl/ftdi_cmd_parser.sv
// Framed command engine: parses A5/CMD/ADDR/LEN/[data]/CHK, drives reg writes/reads, returns read frames.
// Latency: writes start the cycle after CHK; reads emit 4 header bytes, then 2 cycles/data byte, then CHK.
// Backpressure: rd_gnt gates every RX byte; wr_req/wr_data hold until wr_gnt. FTDI_CMD_ACK_EN adds a write ack frame.
module ftdi_cmd_parser #(
    parameter int TIMEOUT_CYC = 65535,
    parameter int ERR_W       = 16
) (
    input  logic              usb_clk,
    input  logic              rst_n,
    ftdi_cmd_parser_if.master bus,
    output logic [ERR_W-1:0]  err_cnt,
    output logic              busy
);
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [3:0] S_HUNT    = 4'd0;
    localparam logic [3:0] S_CMD     = 4'd1;
    localparam logic [3:0] S_ADDR    = 4'd2;
    localparam logic [3:0] S_LEN     = 4'd3;
    localparam logic [3:0] S_DATA    = 4'd4;
    localparam logic [3:0] S_CHK     = 4'd5;
    localparam logic [3:0] S_COMMIT  = 4'd6;
    localparam logic [3:0] S_TX_HDR  = 4'd7;
    localparam logic [3:0] S_TX_RD   = 4'd8;
    localparam logic [3:0] S_TX_CAP  = 4'd9;
    localparam logic [3:0] S_TX_SEND = 4'd10;
    localparam logic [3:0] S_TX_CHK  = 4'd11;
    localparam logic [3:0] S_ACK     = 4'd12;

    logic [3:0]       r_state;
    logic [7:0]       r_cmd, r_addr, r_len, r_cnt, r_sum, r_byte;
    logic [2:0]       r_idx;
    logic [TO_W-1:0]  r_to;
    logic [ERR_W-1:0] r_err;
    logic [7:0]       r_buf [256];

    logic       w_acc, w_timed, w_to_exp, w_last, w_err, w_cmd_ok;
    logic [7:0] w_sum_nxt, w_cur_addr, w_hdr, w_tx_byte;

    assign w_acc      = bus.rd_req & bus.rd_gnt;
    assign w_timed    = (r_state >= S_CMD) && (r_state <= S_CHK);
    assign w_to_exp   = w_timed && !w_acc && (r_to == TO_W'(TIMEOUT_CYC - 1));
    assign w_last     = (r_cnt == r_len - 8'd1);
    assign w_sum_nxt  = r_sum + bus.rd_data;
    assign w_cur_addr = r_addr + r_cnt;
    assign w_cmd_ok   = (bus.rd_data == 8'h01) || (bus.rd_data == 8'h02);
    // TX_CAP forwards the fresh read data; TX_SEND replays the captured copy
    assign w_tx_byte  = (r_state == S_TX_CAP) ? bus.reg_rdata : r_byte;

    // Every way a frame can be dropped; at most one fires per cycle
    assign w_err = (r_state == S_CMD && w_acc && !w_cmd_ok)
                 | (r_state == S_LEN && w_acc && bus.rd_data == 8'h00)
                 | (r_state == S_CHK && w_acc && w_sum_nxt != 8'h00)
                 | w_to_exp;

    // Header byte for the read response (TX) or write ack (ACK) frame
    always_comb begin
        w_hdr = 8'h00;
        case (r_idx)
            3'd0:    w_hdr = 8'h5A;
            3'd1:    w_hdr = (r_state == S_ACK) ? 8'h81 : r_cmd;
            3'd2:    w_hdr = r_addr;
            3'd3:    w_hdr = r_len;
            default: w_hdr = 8'h00 - (8'h81 + r_addr + r_len);
        endcase
    end

    // Output decode; everything is a function of state so reset forces all to 0
    always_comb begin
        bus.rd_req    = rst_n && (r_state <= S_CHK);
        bus.wr_req    = (r_state == S_TX_HDR) || (r_state == S_TX_CAP) || (r_state == S_TX_SEND)
                     || (r_state == S_TX_CHK) || (r_state == S_ACK);
        bus.wr_data   = 8'h00;
        case (r_state)
            S_TX_HDR, S_ACK:     bus.wr_data = w_hdr;
            S_TX_CAP, S_TX_SEND: bus.wr_data = w_tx_byte;
            S_TX_CHK:            bus.wr_data = 8'h00 - r_sum;
            default:             bus.wr_data = 8'h00;
        endcase
        bus.reg_we    = (r_state == S_COMMIT);
        bus.reg_re    = (r_state == S_TX_RD);
        bus.reg_addr  = (r_state == S_COMMIT || r_state == S_TX_RD) ? w_cur_addr : 8'h00;
        bus.reg_wdata = (r_state == S_COMMIT) ? r_buf[r_cnt] : 8'h00;
        err_cnt       = r_err;
        busy          = (r_state != S_HUNT);
    end

    // Payload buffer; contents are don't-care outside a write frame
    always_ff @(posedge usb_clk) begin
        if (r_state == S_DATA && w_acc) r_buf[r_cnt] <= bus.rd_data;
    end

    // Inter-byte timer: runs only while a frame is being received
    always_ff @(posedge usb_clk or negedge rst_n) begin
        if (!rst_n)                            r_to <= '0;
        else if (!w_timed || w_acc || w_to_exp) r_to <= '0;
        else                                   r_to <= r_to + 1'b1;
    end

    // Saturating dropped-frame counter
    always_ff @(posedge usb_clk or negedge rst_n) begin
        if (!rst_n)                                      r_err <= '0;
        else if (w_err && (r_err != {ERR_W{1'b1}}))      r_err <= r_err + 1'b1;
    end

    // Main frame FSM; r_sum carries CMD+ADDR+LEN(+payload), reused as the TX checksum seed
    always_ff @(posedge usb_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_HUNT;
            r_cmd   <= 8'h00;
            r_addr  <= 8'h00;
            r_len   <= 8'h00;
            r_cnt   <= 8'h00;
            r_sum   <= 8'h00;
            r_byte  <= 8'h00;
            r_idx   <= 3'd0;
        end else if (w_to_exp) begin
            r_state <= S_HUNT;
        end else begin
            case (r_state)
                S_HUNT: if (w_acc && bus.rd_data == 8'hA5) r_state <= S_CMD;
                S_CMD: if (w_acc) begin
                    r_cmd   <= bus.rd_data;
                    r_sum   <= bus.rd_data;
                    r_state <= w_cmd_ok ? S_ADDR : S_HUNT;
                end
                S_ADDR: if (w_acc) begin
                    r_addr  <= bus.rd_data;
                    r_sum   <= w_sum_nxt;
                    r_state <= S_LEN;
                end
                S_LEN: if (w_acc) begin
                    r_len   <= bus.rd_data;
                    r_sum   <= w_sum_nxt;
                    r_cnt   <= 8'h00;
                    if (bus.rd_data == 8'h00)  r_state <= S_HUNT;
                    else if (r_cmd == 8'h01)   r_state <= S_DATA;
                    else                       r_state <= S_CHK;
                end
                S_DATA: if (w_acc) begin
                    r_sum <= w_sum_nxt;
                    if (w_last) r_state <= S_CHK;
                    else        r_cnt   <= r_cnt + 8'd1;
                end
                S_CHK: if (w_acc) begin
                    r_cnt <= 8'h00;
                    r_idx <= 3'd0;
                    if (w_sum_nxt != 8'h00)   r_state <= S_HUNT;
                    else if (r_cmd == 8'h01)  r_state <= S_COMMIT;
                    else                      r_state <= S_TX_HDR;
                end
                S_COMMIT: begin
                    if (w_last) begin
`ifdef FTDI_CMD_ACK_EN
                        r_idx   <= 3'd0;
                        r_state <= S_ACK;
`else
                        r_state <= S_HUNT;
`endif
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_TX_HDR: if (bus.wr_gnt) begin
                    if (r_idx == 3'd3) r_state <= S_TX_RD;
                    else               r_idx   <= r_idx + 3'd1;
                end
                S_TX_RD: r_state <= S_TX_CAP;
                S_TX_CAP, S_TX_SEND: begin
                    if (r_state == S_TX_CAP) r_byte <= bus.reg_rdata;
                    if (bus.wr_gnt) begin
                        r_sum <= r_sum + w_tx_byte;
                        if (w_last) begin
                            r_state <= S_TX_CHK;
                        end else begin
                            r_cnt   <= r_cnt + 8'd1;
                            r_state <= S_TX_RD;
                        end
                    end else begin
                        r_state <= S_TX_SEND;
                    end
                end
                S_TX_CHK: if (bus.wr_gnt) r_state <= S_HUNT;
                S_ACK: if (bus.wr_gnt) begin
                    if (r_idx == 3'd4) r_state <= S_HUNT;
                    else               r_idx   <= r_idx + 3'd1;
                end
                default: r_state <= S_HUNT;
            endcase
        end
    end
endmodule

// File: tb/tb_ftdi_cmd_parser.sv
// Directed bench for ftdi_cmd_parser: write/read frames, bad checksum, junk, LEN=0, timeout, reset mid-TX.
// Latency: checks TX pacing against the 2-cycles-per-byte bound.
// Backpressure: wr_gnt driven always-1, one-in-three, or never.
`timescale 1ns/1ps
module tb_ftdi_cmd_parser;
    logic        usb_clk = 1'b0;
    logic        rst_n   = 1'b0;
    logic [15:0] err_cnt;
    logic        busy;

    ftdi_cmd_parser_if bus();

    ftdi_cmd_parser #(.TIMEOUT_CYC(16), .ERR_W(16)) dut (
        .usb_clk (usb_clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .err_cnt (err_cnt),
        .busy    (busy)
    );

    always #5 usb_clk = ~usb_clk;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Observed traffic, collected at negedge
    logic [7:0] wrq [$];
    logic [7:0] weaq [$];
    logic [7:0] wedq [$];
    int         wecq [$];
    logic [7:0] req [$];
    int         cyc = 0;
    int         wr_first = 0;
    int         wr_last = 0;
    logic       hold_v = 1'b0;
    logic [7:0] hold_d = 8'h00;

    initial begin
        forever begin
            @(negedge usb_clk);
            cyc++;
            if (bus.reg_we) begin
                weaq.push_back(bus.reg_addr);
                wedq.push_back(bus.reg_wdata);
                wecq.push_back(cyc);
            end
            if (bus.reg_re) req.push_back(bus.reg_addr);
            if (hold_v && bus.wr_req) chk("wr_data hold", {24'h0, bus.wr_data}, {24'h0, hold_d});
            if (bus.wr_req && bus.wr_gnt) begin
                if (wrq.size() == 0) wr_first = cyc;
                wr_last = cyc;
                wrq.push_back(bus.wr_data);
            end
            hold_v = bus.wr_req && !bus.wr_gnt;
            hold_d = bus.wr_data;
        end
    end

    // wr_gnt pattern: 0 = always, 1 = one cycle in three, 2 = never
    int gnt_mode = 0;
    initial begin
        int k = 0;
        bus.wr_gnt = 1'b1;
        forever begin
            @(posedge usb_clk);
            #1;
            k++;
            case (gnt_mode)
                0:       bus.wr_gnt = 1'b1;
                1:       bus.wr_gnt = (k % 3 == 0);
                default: bus.wr_gnt = 1'b0;
            endcase
        end
    end

    // Register file model: data valid for exactly the cycle after reg_re, junk otherwise
    logic [7:0] regs [256];
    initial begin
        logic       p;
        logic [7:0] a;
        bus.reg_rdata = 8'hEE;
        forever begin
            @(negedge usb_clk);
            p = bus.reg_re;
            a = bus.reg_addr;
            @(posedge usb_clk);
            #1;
            bus.reg_rdata = p ? regs[a] : 8'hEE;
        end
    end

    task automatic clear_q();
        wrq.delete(); weaq.delete(); wedq.delete(); wecq.delete(); req.delete();
    endtask

    // Offer one RX byte until the DUT takes it; called and returns at a negedge
    task automatic send(input logic [7:0] b);
        int n = 0;
        bus.rd_data = b;
        bus.rd_gnt  = 1'b1;
        while (!bus.rd_req && n < 300) begin
            @(negedge usb_clk);
            n++;
        end
        if (n >= 300) chk("rd_req wait", {31'h0, bus.rd_req}, 32'h1);
        @(negedge usb_clk);
        bus.rd_gnt = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 300) begin
            @(negedge usb_clk);
            n++;
        end
        chk(tag, {31'h0, busy}, 32'h0);
    endtask

    logic [7:0] exp_rd1 [6] = '{8'h5A, 8'h02, 8'h20, 8'h01, 8'h3C, 8'hA1};
    // 02+FF+02 = 03 mod 256, so FD closes the request; response sum 02+FF+02+11+22 = 36 -> CHK CA
    logic [7:0] exp_rd2 [7] = '{8'h5A, 8'h02, 8'hFF, 8'h02, 8'h11, 8'h22, 8'hCA};
    logic [7:0] exp_ack [5] = '{8'h5A, 8'h81, 8'h10, 8'h02, 8'h6D};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.rd_gnt  = 1'b0;
        bus.rd_data = 8'h00;
        for (int i = 0; i < 256; i++) regs[i] = 8'h00;
        regs[8'h20] = 8'h3C;
        regs[8'hFF] = 8'h11;
        regs[8'h00] = 8'h22;

        // Reset state
        repeat (3) @(negedge usb_clk);
        chk("rst rd_req",   {31'h0, bus.rd_req},   32'h0);
        chk("rst wr_req",   {31'h0, bus.wr_req},   32'h0);
        chk("rst wr_data",  {24'h0, bus.wr_data},  32'h0);
        chk("rst reg_we",   {31'h0, bus.reg_we},   32'h0);
        chk("rst reg_re",   {31'h0, bus.reg_re},   32'h0);
        chk("rst reg_addr", {24'h0, bus.reg_addr}, 32'h0);
        chk("rst err_cnt",  {16'h0, err_cnt},      32'h0);
        chk("rst busy",     {31'h0, busy},         32'h0);
        rst_n = 1'b1;
        @(negedge usb_clk);
        chk("hunt rd_req",  {31'h0, bus.rd_req},   32'h1);

        // Good write frame
        clear_q();
        send(8'hA5); send(8'h01); send(8'h10); send(8'h02); send(8'hAA); send(8'hBB); send(8'h88);
        wait_idle("wr1 idle");
        chk("wr1 we count", weaq.size(), 2);
        chk("wr1 addr0",  {24'h0, weaq[0]}, 32'h10);
        chk("wr1 data0",  {24'h0, wedq[0]}, 32'hAA);
        chk("wr1 addr1",  {24'h0, weaq[1]}, 32'h11);
        chk("wr1 data1",  {24'h0, wedq[1]}, 32'hBB);
        chk("wr1 back-to-back", wecq[1] - wecq[0], 1);
        chk("wr1 err_cnt", {16'h0, err_cnt}, 32'h0);
`ifdef FTDI_CMD_ACK_EN
        chk("ack count", wrq.size(), 5);
        for (int i = 0; i < 5; i++) chk($sformatf("ack byte%0d", i), {24'h0, wrq[i]}, {24'h0, exp_ack[i]});
`else
        chk("wr1 silent", wrq.size(), 0);
`endif

        // Good read frame, wr_gnt always 1
        clear_q();
        send(8'hA5); send(8'h02); send(8'h20); send(8'h01); send(8'hDD);
        wait_idle("rd1 idle");
        chk("rd1 tx count", wrq.size(), 6);
        for (int i = 0; i < 6; i++) chk($sformatf("rd1 byte%0d", i), {24'h0, wrq[i]}, {24'h0, exp_rd1[i]});
        chk("rd1 re count", req.size(), 1);
        chk("rd1 re addr", {24'h0, req[0]}, 32'h20);
        chk("rd1 pace", {31'h0, (wr_last - wr_first) <= 10}, 32'h1);
        chk("rd1 no we", weaq.size(), 0);

        // Bad checksum, then recovery
        clear_q();
        send(8'hA5); send(8'h01); send(8'h10); send(8'h02); send(8'hAA); send(8'hBB); send(8'h89);
        chk("badchk busy", {31'h0, busy}, 32'h0);
        chk("badchk err_cnt", {16'h0, err_cnt}, 32'h1);
        chk("badchk no we", weaq.size(), 0);
        chk("badchk no tx", wrq.size(), 0);
        send(8'hA5); send(8'h01); send(8'h10); send(8'h02); send(8'hAA); send(8'hBB); send(8'h88);
        wait_idle("wr2 idle");
        chk("wr2 we count", weaq.size(), 2);
        chk("wr2 data1", {24'h0, wedq[1]}, 32'hBB);
        chk("wr2 err_cnt", {16'h0, err_cnt}, 32'h1);

        // Read with address wrap and throttled wr_gnt
        gnt_mode = 1;
        clear_q();
        send(8'hA5); send(8'h02); send(8'hFF); send(8'h02); send(8'hFD);
        wait_idle("rd2 idle");
        gnt_mode = 0;
        chk("rd2 re count", req.size(), 2);
        chk("rd2 re addr0", {24'h0, req[0]}, 32'hFF);
        chk("rd2 re addr1", {24'h0, req[1]}, 32'h00);
        chk("rd2 tx count", wrq.size(), 7);
        for (int i = 0; i < 7; i++) chk($sformatf("rd2 byte%0d", i), {24'h0, wrq[i]}, {24'h0, exp_rd2[i]});

        // Reset while a TX byte is stalled
        gnt_mode = 2;
        clear_q();
        send(8'hA5); send(8'h02); send(8'h20); send(8'h01); send(8'hDD);
        begin
            int n = 0;
            while (!bus.wr_req && n < 50) begin
                @(negedge usb_clk);
                n++;
            end
        end
        chk("stall wr_req", {31'h0, bus.wr_req}, 32'h1);
        chk("stall wr_data", {24'h0, bus.wr_data}, 32'h5A);
        repeat (3) @(negedge usb_clk);
        rst_n = 1'b0;
        #1;
        chk("midtx rst wr_req", {31'h0, bus.wr_req}, 32'h0);
        chk("midtx rst busy",   {31'h0, busy},       32'h0);
        chk("midtx rst err",    {16'h0, err_cnt},    32'h0);
        @(negedge usb_clk);
        rst_n = 1'b1;
        gnt_mode = 0;
        repeat (4) @(negedge usb_clk);
        chk("midtx no tx", wrq.size(), 0);
        chk("midtx stays idle", {31'h0, busy}, 32'h0);

        // Junk then an illegal command
        clear_q();
        send(8'h00); send(8'h13); send(8'hA5); send(8'h07);
        chk("badcmd err_cnt", {16'h0, err_cnt}, 32'h1);
        chk("badcmd busy", {31'h0, busy}, 32'h0);
        send(8'hA5); send(8'h02); send(8'h20); send(8'h01); send(8'hDD);
        wait_idle("rd3 idle");
        chk("rd3 tx count", wrq.size(), 6);
        chk("rd3 data", {24'h0, wrq[4]}, 32'h3C);
        chk("rd3 chk",  {24'h0, wrq[5]}, 32'hA1);

        // LEN = 0 is rejected
        send(8'hA5); send(8'h02); send(8'h30); send(8'h00);
        chk("len0 err_cnt", {16'h0, err_cnt}, 32'h2);
        chk("len0 busy", {31'h0, busy}, 32'h0);

        // Inter-byte timeout after A5 01 (16-cycle limit)
        send(8'hA5); send(8'h01);
        repeat (14) @(negedge usb_clk);
        chk("to early busy", {31'h0, busy}, 32'h1);
        chk("to early err", {16'h0, err_cnt}, 32'h2);
        repeat (3) @(negedge usb_clk);
        chk("to busy", {31'h0, busy}, 32'h0);
        chk("to err_cnt", {16'h0, err_cnt}, 32'h3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
